id_stage_scoreboard: RTL

- Parametrised decode stage for the pipelined MIPS core. Sits between the IF/ID register and EX.
- Decodes the ID instruction and extends its immediate.
- Tracks in-flight register writes in a scoreboard that is FWD_STAGES deep.
- Produces per-operand forward selects and load-use stalls for any load latency, and owns the ID/EX pipeline register, including bubble insertion on stall and flush.

---
 rtl/id_stage_scoreboard_if.sv | 53 +++++
 rtl/id_stage_scoreboard.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_scoreboard_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : id_stage_scoreboard_if                                     |
// | Description : Bundle between the IF/ID register, the decode stage and    |
// |               EX. The master side feeds the ID instruction and consumes  |
// |               stall/jump/ID-EX outputs; the slave side is the ID stage.  |
// | Ports       : idValid, instruction, pc_4, flush        (master -> slave) |
// |               shouldStall, isJump, jumpTarget, ex*     (slave -> master) |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface id_stage_scoreboard_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int SEL_W          = 2
);
  logic                      idValid;
  logic [31:0]               instruction;
  logic [DATA_WIDTH-1:0]     pc_4;
  logic                      flush;
  logic                      shouldStall;
  logic                      isJump;
  logic [DATA_WIDTH-1:0]     jumpTarget;
  logic                      exValid;
  logic [4:0]                exAluOperation;
  logic [DATA_WIDTH-1:0]     exImmediate;
  logic                      exUseImmediate;
  logic                      exUseShiftAmount;
  logic [REG_ADDR_WIDTH-1:0] exDest;
  logic                      exWriteRegister;
  logic                      exMemRead;
  logic                      exMemWrite;
  logic                      exIsBranch;
  logic                      exIsBne;
  logic [SEL_W-1:0]          exFwdSelA;
  logic [SEL_W-1:0]          exFwdSelB;

  modport master (
    output idValid, instruction, pc_4, flush,
    input  shouldStall, isJump, jumpTarget, exValid, exAluOperation,
           exImmediate, exUseImmediate, exUseShiftAmount, exDest,
           exWriteRegister, exMemRead, exMemWrite, exIsBranch, exIsBne,
           exFwdSelA, exFwdSelB
  );

  modport slave (
    input  idValid, instruction, pc_4, flush,
    output shouldStall, isJump, jumpTarget, exValid, exAluOperation,
           exImmediate, exUseImmediate, exUseShiftAmount, exDest,
           exWriteRegister, exMemRead, exMemWrite, exIsBranch, exIsBne,
           exFwdSelA, exFwdSelB
  );
endinterface
`default_nettype wire

// File: rtl/id_stage_scoreboard.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : id_stage_scoreboard                                        |
// | Description : MIPS decode stage. Decodes the ID instruction, extends its |
// |               immediate, tracks in-flight writes in a FWD_STAGES-deep    |
// |               scoreboard, computes forward selects and load-use stalls,  |
// |               and owns the ID/EX pipeline register.                      |
// | Ports       : clock  - rising-edge clock                                 |
// |               resetN - asynchronous active-low reset                     |
// |               bus    - slave side of id_stage_scoreboard_if              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module id_stage_scoreboard #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int FWD_STAGES     = 2,
  parameter int LOAD_LATENCY   = 1,
  parameter int SEL_W          = $clog2(FWD_STAGES + 1)
) (
  input logic                  clock,
  input logic                  resetN,
  id_stage_scoreboard_if.slave bus
);

  localparam logic [4:0] c_ALU_ADD = 5'd0, c_ALU_SUB = 5'd1, c_ALU_AND = 5'd2,
                         c_ALU_OR  = 5'd3, c_ALU_XOR = 5'd4, c_ALU_SLT = 5'd5,
                         c_ALU_SLL = 5'd6, c_ALU_SRL = 5'd7, c_ALU_SRA = 5'd8,
                         c_ALU_LUI = 5'd9;

  // Decode fields
  logic [5:0]                w_opcode, w_funct;
  logic [REG_ADDR_WIDTH-1:0] w_rs, w_rt, w_rd, w_dest;
  logic [15:0]               w_imm16;
  logic [DATA_WIDTH-1:0]     w_imm;
  logic [4:0]                w_aluOp;
  logic w_useImm, w_useShamt, w_writes, w_writeReg, w_memRead, w_memWrite;
  logic w_isBranch, w_isBne, w_isJump, w_readsRs, w_readsRt;

  // Hazard results
  logic [SEL_W-1:0] w_selA, w_selB;
  logic             w_loadHitA, w_loadHitB, w_stall, w_issue;

  // Scoreboard: entry k describes the producer k stages past ID
  logic                      r_sbValid [1:FWD_STAGES];
  logic                      r_sbWrite [1:FWD_STAGES];
  logic                      r_sbLoad  [1:FWD_STAGES];
  logic [REG_ADDR_WIDTH-1:0] r_sbDest  [1:FWD_STAGES];

  // ID/EX register
  logic                      r_exValid, r_exUseImm, r_exUseShamt, r_exWriteReg;
  logic                      r_exMemRead, r_exMemWrite, r_exIsBranch, r_exIsBne;
  logic [4:0]                r_exAluOp;
  logic [DATA_WIDTH-1:0]     r_exImm;
  logic [REG_ADDR_WIDTH-1:0] r_exDest;
  logic [SEL_W-1:0]          r_exSelA, r_exSelB;

  assign w_opcode = bus.instruction[31:26];
  assign w_funct  = bus.instruction[5:0];
  assign w_rs     = REG_ADDR_WIDTH'(bus.instruction[25:21]);
  assign w_rt     = REG_ADDR_WIDTH'(bus.instruction[20:16]);
  assign w_rd     = REG_ADDR_WIDTH'(bus.instruction[15:11]);
  assign w_imm16  = bus.instruction[15:0];

  always_comb begin
    w_aluOp    = c_ALU_ADD;
    w_useImm   = 1'b0;
    w_useShamt = 1'b0;
    w_dest     = w_rt;
    w_writes   = 1'b0;
    w_memRead  = 1'b0;
    w_memWrite = 1'b0;
    w_isBranch = 1'b0;
    w_isBne    = 1'b0;
    w_isJump   = 1'b0;
    w_readsRs  = 1'b0;
    w_readsRt  = 1'b0;
    // Sign-extended by default; for R-type this also carries shamt in [10:6]
    w_imm      = {{(DATA_WIDTH-16){w_imm16[15]}}, w_imm16};
    case (w_opcode)
      6'h00: begin
        w_dest = w_rd;
        case (w_funct)
          6'h20: begin w_aluOp = c_ALU_ADD; w_writes = 1'b1; w_readsRs = 1'b1; w_readsRt = 1'b1; end
          6'h22: begin w_aluOp = c_ALU_SUB; w_writes = 1'b1; w_readsRs = 1'b1; w_readsRt = 1'b1; end
          6'h24: begin w_aluOp = c_ALU_AND; w_writes = 1'b1; w_readsRs = 1'b1; w_readsRt = 1'b1; end
          6'h25: begin w_aluOp = c_ALU_OR;  w_writes = 1'b1; w_readsRs = 1'b1; w_readsRt = 1'b1; end
          6'h26: begin w_aluOp = c_ALU_XOR; w_writes = 1'b1; w_readsRs = 1'b1; w_readsRt = 1'b1; end
          6'h2A: begin w_aluOp = c_ALU_SLT; w_writes = 1'b1; w_readsRs = 1'b1; w_readsRt = 1'b1; end
          6'h00: begin w_aluOp = c_ALU_SLL; w_writes = 1'b1; w_readsRt = 1'b1; w_useShamt = 1'b1; end
          6'h02: begin w_aluOp = c_ALU_SRL; w_writes = 1'b1; w_readsRt = 1'b1; w_useShamt = 1'b1; end
          6'h03: begin w_aluOp = c_ALU_SRA; w_writes = 1'b1; w_readsRt = 1'b1; w_useShamt = 1'b1; end
          6'h08: w_readsRs = 1'b1;  // jr: register target only, no write
          default: ;
        endcase
      end
      6'h08: begin w_writes = 1'b1; w_readsRs = 1'b1; w_useImm = 1'b1; end
      6'h0C: begin w_aluOp = c_ALU_AND; w_writes = 1'b1; w_readsRs = 1'b1; w_useImm = 1'b1;
                   w_imm = DATA_WIDTH'(w_imm16); end
      6'h0D: begin w_aluOp = c_ALU_OR;  w_writes = 1'b1; w_readsRs = 1'b1; w_useImm = 1'b1;
                   w_imm = DATA_WIDTH'(w_imm16); end
      6'h0E: begin w_aluOp = c_ALU_XOR; w_writes = 1'b1; w_readsRs = 1'b1; w_useImm = 1'b1;
                   w_imm = DATA_WIDTH'(w_imm16); end
      6'h0F: begin w_aluOp = c_ALU_LUI; w_writes = 1'b1; w_useImm = 1'b1;
                   w_imm = DATA_WIDTH'({w_imm16, 16'h0000}); end
      6'h23: begin w_writes = 1'b1; w_memRead = 1'b1; w_readsRs = 1'b1; w_useImm = 1'b1; end
      6'h2B: begin w_memWrite = 1'b1; w_readsRs = 1'b1; w_readsRt = 1'b1; w_useImm = 1'b1; end
      6'h04: begin w_aluOp = c_ALU_SUB; w_isBranch = 1'b1; w_readsRs = 1'b1; w_readsRt = 1'b1; end
      6'h05: begin w_aluOp = c_ALU_SUB; w_isBranch = 1'b1; w_isBne = 1'b1;
                   w_readsRs = 1'b1; w_readsRt = 1'b1; end
      6'h02: w_isJump = 1'b1;
      // jal: link value pc_4 rides in the immediate so EX computes 0 + pc_4
      6'h03: begin w_isJump = 1'b1; w_writes = 1'b1; w_dest = REG_ADDR_WIDTH'(5'd31);
                   w_useImm = 1'b1; w_imm = bus.pc_4; end
      default: ;
    endcase
  end

  assign w_writeReg = w_writes & (w_dest != '0);

  // Walk oldest to youngest so the youngest matching producer wins, which
  // lets a younger non-load producer shadow an older load.
  always_comb begin
    w_selA     = '0;
    w_selB     = '0;
    w_loadHitA = 1'b0;
    w_loadHitB = 1'b0;
    for (int k = FWD_STAGES; k >= 1; k--) begin
      if (w_readsRs && (w_rs != '0) && r_sbValid[k] && r_sbWrite[k] && (r_sbDest[k] == w_rs)) begin
        w_selA     = SEL_W'(k);
        w_loadHitA = r_sbLoad[k] && (k <= LOAD_LATENCY);
      end
      if (w_readsRt && (w_rt != '0) && r_sbValid[k] && r_sbWrite[k] && (r_sbDest[k] == w_rt)) begin
        w_selB     = SEL_W'(k);
        w_loadHitB = r_sbLoad[k] && (k <= LOAD_LATENCY);
      end
    end
  end

  assign w_stall = bus.idValid & ~bus.flush & (w_loadHitA | w_loadHitB);
  assign w_issue = bus.idValid & ~bus.flush & ~w_stall;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_exValid <= 1'b0; r_exAluOp <= '0; r_exImm <= '0; r_exUseImm <= 1'b0;
      r_exUseShamt <= 1'b0; r_exDest <= '0; r_exWriteReg <= 1'b0;
      r_exMemRead <= 1'b0; r_exMemWrite <= 1'b0; r_exIsBranch <= 1'b0;
      r_exIsBne <= 1'b0; r_exSelA <= '0; r_exSelB <= '0;
    end else if (w_issue) begin
      r_exValid <= 1'b1; r_exAluOp <= w_aluOp; r_exImm <= w_imm; r_exUseImm <= w_useImm;
      r_exUseShamt <= w_useShamt; r_exDest <= w_dest; r_exWriteReg <= w_writeReg;
      r_exMemRead <= w_memRead; r_exMemWrite <= w_memWrite; r_exIsBranch <= w_isBranch;
      r_exIsBne <= w_isBne; r_exSelA <= w_selA; r_exSelB <= w_selB;
    end else begin
      r_exValid <= 1'b0; r_exAluOp <= '0; r_exImm <= '0; r_exUseImm <= 1'b0;
      r_exUseShamt <= 1'b0; r_exDest <= '0; r_exWriteReg <= 1'b0;
      r_exMemRead <= 1'b0; r_exMemWrite <= 1'b0; r_exIsBranch <= 1'b0;
      r_exIsBne <= 1'b0; r_exSelA <= '0; r_exSelB <= '0;
    end
  end

  // Entry 1 tracks exactly what is loaded into ID/EX; older entries shift.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      for (int k = 1; k <= FWD_STAGES; k++) begin
        r_sbValid[k] <= 1'b0;
        r_sbWrite[k] <= 1'b0;
        r_sbLoad[k]  <= 1'b0;
        r_sbDest[k]  <= '0;
      end
    end else begin
      r_sbValid[1] <= w_issue;
      r_sbWrite[1] <= w_issue & w_writeReg;
      r_sbLoad[1]  <= w_issue & w_memRead;
      r_sbDest[1]  <= w_issue ? w_dest : '0;
      for (int k = 2; k <= FWD_STAGES; k++) begin
        r_sbValid[k] <= r_sbValid[k-1];
        r_sbWrite[k] <= r_sbWrite[k-1];
        r_sbLoad[k]  <= r_sbLoad[k-1];
        r_sbDest[k]  <= r_sbDest[k-1];
      end
    end
  end

  assign bus.shouldStall      = w_stall;
  assign bus.isJump           = bus.idValid & w_isJump;
  assign bus.jumpTarget       = {bus.pc_4[DATA_WIDTH-1:28], bus.instruction[25:0], 2'b00};
  assign bus.exValid          = r_exValid;
  assign bus.exAluOperation   = r_exAluOp;
  assign bus.exImmediate      = r_exImm;
  assign bus.exUseImmediate   = r_exUseImm;
  assign bus.exUseShiftAmount = r_exUseShamt;
  assign bus.exDest           = r_exDest;
  assign bus.exWriteRegister  = r_exWriteReg;
  assign bus.exMemRead        = r_exMemRead;
  assign bus.exMemWrite       = r_exMemWrite;
  assign bus.exIsBranch       = r_exIsBranch;
  assign bus.exIsBne          = r_exIsBne;
  assign bus.exFwdSelA        = r_exSelA;
  assign bus.exFwdSelB        = r_exSelB;

endmodule
`default_nettype wire
